// File: rtl/inst_fetch_buffer.sv
// Fetch-to-decode FIFO, first-word fall-through head; write-to-read latency 1 cycle, no bypass.
// Fetch stalls on buf_full; writes while full with no read are dropped and flag overflow_err.
module inst_fetch_buffer #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_valid,
    input  logic [ADDR_WIDTH-1:0]      wr_pc,
    input  logic [ADDR_WIDTH-1:0]      wr_pc4,
    input  logic [INST_WIDTH-1:0]      wr_inst,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [ADDR_WIDTH-1:0]      rd_pc,
    output logic [ADDR_WIDTH-1:0]      rd_pc4,
    output logic [INST_WIDTH-1:0]      rd_inst,
    output logic                       buf_empty,
    output logic                       buf_full,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    output logic                       overflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc4_mem  [DEPTH];
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_rd_fire;
    logic w_wr_fire;

    // Status comes only from the registered count so fetch sees no input-to-output paths.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_rd_fire = !w_empty && rd_ready;
    assign w_wr_fire = wr_valid && (!w_full || w_rd_fire) && !flush;

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_pc_mem[r_tail]   <= wr_pc;
            r_pc4_mem[r_tail]  <= wr_pc4;
            r_inst_mem[r_tail] <= wr_inst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_fire)
                r_tail <= r_tail + PTR_W'(1);
            if (w_rd_fire)
                r_head <= r_head + PTR_W'(1);
            if (w_wr_fire && !w_rd_fire)
                r_count <= r_count + CNT_W'(1);
            else if (!w_wr_fire && w_rd_fire)
                r_count <= r_count - CNT_W'(1);
            if (wr_valid && w_full && !w_rd_fire)
                r_overflow <= 1'b1;
        end
    end

    assign rd_valid     = !w_empty;
    assign rd_pc        = w_empty ? '0 : r_pc_mem[r_head];
    assign rd_pc4       = w_empty ? '0 : r_pc4_mem[r_head];
    assign rd_inst      = w_empty ? '0 : r_inst_mem[r_head];
    assign buf_empty    = w_empty;
    assign buf_full     = w_full;
    assign buf_count    = r_count;
    assign overflow_err = r_overflow;
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_inst_fetch_buffer;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_pc = '0;
    logic [AW-1:0] wr_pc4 = '0;
    logic [IW-1:0] wr_inst = '0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [AW-1:0] rd_pc;
    logic [AW-1:0] rd_pc4;
    logic [IW-1:0] rd_inst;
    logic          buf_empty;
    logic          buf_full;
    logic [2:0]    buf_count;
    logic          overflow_err;

    int errors = 0;
    int checks = 0;

    inst_fetch_buffer #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_valid(wr_valid), .wr_pc(wr_pc), .wr_pc4(wr_pc4), .wr_inst(wr_inst),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_pc4(rd_pc4),
        .rd_inst(rd_inst), .buf_empty(buf_empty), .buf_full(buf_full),
        .buf_count(buf_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
        logic [IW-1:0] inst;
    } entry_t;

    entry_t m_q[$];
    bit     m_ovf = 0;

    // Reference: a plain queue updated from the rules on each rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_ovf = 0;
        end else begin
            int  sz;
            bit  rfire;
            sz = m_q.size();
            rfire = (sz > 0) && rd_ready;
            if (flush) begin
                m_q.delete();
                m_ovf = 0;
            end else begin
                if (rfire) void'(m_q.pop_front());
                if (wr_valid) begin
                    if (sz < DEPTH || rfire) m_q.push_back({wr_pc, wr_pc4, wr_inst});
                    else m_ovf = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            entry_t h;
            bit     v;
            v = (m_q.size() != 0);
            h = v ? m_q[0] : '0;
            chk("cmp_rd_valid", 64'(rd_valid), 64'(v));
            chk("cmp_rd_pc", rd_pc, h.pc);
            chk("cmp_rd_pc4", rd_pc4, h.pc4);
            chk("cmp_rd_inst", 64'(rd_inst), 64'(h.inst));
            chk("cmp_count", 64'(buf_count), 64'(m_q.size()));
            chk("cmp_empty", 64'(buf_empty), 64'(m_q.size() == 0));
            chk("cmp_full", 64'(buf_full), 64'(m_q.size() == DEPTH));
            chk("cmp_ovf", 64'(overflow_err), 64'(m_ovf));
        end
    end

    // Called at a falling edge: apply inputs, return at the next falling edge.
    task automatic tick(input bit wv, input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                        input bit rr, input bit fl);
        wr_valid = wv;
        wr_pc    = pc;
        wr_pc4   = pc + 64'd4;
        wr_inst  = inst;
        rd_ready = rr;
        flush    = fl;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_empty", 64'(buf_empty), 64'd1);
        chk("reset_count", 64'(buf_count), 64'd0);
        chk("reset_valid", 64'(rd_valid), 64'd0);
        chk("reset_full", 64'(buf_full), 64'd0);
        chk("reset_rd_pc", rd_pc, 64'd0);
        chk("reset_ovf", 64'(overflow_err), 64'd0);

        // 1: single write, visible one cycle later
        tick(1, 64'h1000, 32'h00000013, 0, 0);
        chk("t1_valid", 64'(rd_valid), 64'd1);
        chk("t1_pc", rd_pc, 64'h1000);
        chk("t1_pc4", rd_pc4, 64'h1004);
        chk("t1_count", 64'(buf_count), 64'd1);
        tick(0, 0, 0, 0, 1);

        // 2: fill, then overflow
        for (int i = 0; i < 4; i++) tick(1, 64'(i * 4), 32'(i + 100), 0, 0);
        chk("t2_full", 64'(buf_full), 64'd1);
        chk("t2_count", 64'(buf_count), 64'd4);
        tick(1, 64'h10, 32'h55, 0, 0);
        chk("t2_ovf", 64'(overflow_err), 64'd1);
        chk("t2_head", rd_pc, 64'h0);
        chk("t2_count_after", 64'(buf_count), 64'd4);

        // 3: full with simultaneous read and write
        tick(1, 64'h10, 32'h66, 1, 0);
        chk("t3_count", 64'(buf_count), 64'd4);
        chk("t3_head", rd_pc, 64'h4);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
        chk("t3_last", rd_pc, 64'h10);
        chk("t3_last_inst", 64'(rd_inst), 64'h66);
        chk("t3_ovf_sticky", 64'(overflow_err), 64'd1);
        tick(0, 0, 0, 1, 0);
        chk("t3_drained", 64'(buf_empty), 64'd1);

        // 4: flush with concurrent write
        for (int i = 0; i < 3; i++) tick(1, 64'h200 + 64'(i * 4), 32'(i), 0, 0);
        tick(1, 64'h50, 32'h77, 0, 1);
        chk("t4_empty", 64'(buf_empty), 64'd1);
        chk("t4_count", 64'(buf_count), 64'd0);
        chk("t4_rd_pc", rd_pc, 64'd0);
        chk("t4_ovf", 64'(overflow_err), 64'd0);
        tick(1, 64'h60, 32'h88, 0, 0);
        chk("t4_new_head", rd_pc, 64'h60);
        tick(0, 0, 0, 1, 0);

        // 5: streaming with rd_ready held high
        for (int i = 0; i < 10; i++) begin
            tick(1, 64'h3000 + 64'(i * 4), 32'(i + 7), 1, 0);
            chk("t5_pc", rd_pc, 64'h3000 + 64'(i * 4));
            chk("t5_count_le1", 64'(buf_count <= 3'd1), 64'd1);
        end
        tick(0, 0, 0, 1, 0);

        // 6: asynchronous reset between clock edges
        tick(1, 64'h400, 32'h1, 0, 0);
        tick(1, 64'h404, 32'h2, 0, 0);
        wr_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", 64'(rd_valid), 64'd0);
        chk("t6_count", 64'(buf_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] pc;
            pc = {32'($urandom), 32'($urandom)} & ~64'd3;
            tick($urandom_range(0, 3) != 0, pc, 32'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        tick(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
